// File: rtl/genie_mem_responder_pkg.sv
// Shared definitions for the accelerator-to-SRAM memory responder.
//   MEM_AW  : width of the accelerator word address
//   MEM_DW  : data word width
//   state_e : responder FSM encoding
package genie_mem_responder_pkg;

  localparam int MEM_AW = 26;
  localparam int MEM_DW = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STALL  = 3'd1,
    ACCESS = 3'd2,
    RWAIT  = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/genie_mem_responder.sv
// Single-outstanding memory responder between an accelerator request port and
// a synchronous SRAM with RD_LAT cycles of read latency.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wvalid/waddr/wdata  : write request, held until the wready pulse
//   rvalid/raddr        : read request, held until the rready pulse
//   wready, rready      : one-cycle completion pulses; rdata valid with rready
//   wait_cyc            : extra stall cycles, captured when a request is taken
//   err_clr, err_oob    : sticky out-of-range flag and its clear
//   sram_*              : SRAM port (cen = enable, wen qualifies cen)
// Every output comes from a flop or from a decode of state/direction flops,
// so no request input reaches an output combinationally.
module genie_mem_responder
  import genie_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wvalid,
  output logic              wready,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [MEM_DW-1:0] wdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [MEM_AW-1:0] raddr,
  output logic [MEM_DW-1:0] rdata,
  input  logic [3:0]        wait_cyc,
  input  logic              err_clr,
  output logic              err_oob,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MEM_DW-1:0] sram_wdata,
  input  logic [MEM_DW-1:0] sram_rdata
);

  state_e              state_q, state_d;
  logic                dir_wr_q, dir_wr_d;    // direction of the request in flight
  logic                last_wr_q, last_wr_d;  // round-robin: last grant was a write
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [MEM_DW-1:0]   data_q, data_d;
  logic [3:0]          stall_cnt_q, stall_cnt_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic [MEM_DW-1:0]   rdata_q, rdata_d;
  logic                err_oob_q, err_oob_d;
  logic                sram_cen_q, sram_cen_d;
  logic                sram_wen_q, sram_wen_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [MEM_DW-1:0]   sram_wdata_q, sram_wdata_d;

  logic accept, grant_wr, to_access, oob_d;

  // Any address bit above the SRAM depth marks the access out of range.
  function automatic logic is_oob(input logic [MEM_AW-1:0] a);
    return (a >> ADDR_W) != '0;
  endfunction

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rvalid || wvalid) state_d = (wait_cyc != 4'd0) ? STALL : ACCESS;
      STALL:   if (stall_cnt_q == 4'd1) state_d = ACCESS;
      ACCESS:  state_d = dir_wr_q ? RESP : RWAIT;
      RWAIT:   if (lat_cnt_q == 3'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs / datapath next values ----
  always_comb begin
    // Reads win a tie unless the previous grant was also a read.
    grant_wr  = wvalid && (!rvalid || !last_wr_q);
    accept    = (state_q == IDLE) && (rvalid || wvalid);

    dir_wr_d  = accept ? grant_wr : dir_wr_q;
    last_wr_d = accept ? grant_wr : last_wr_q;
    addr_d    = accept ? (grant_wr ? waddr : raddr) : addr_q;
    data_d    = (accept && grant_wr) ? wdata : data_q;

    stall_cnt_d = stall_cnt_q;
    if (accept)                 stall_cnt_d = wait_cyc;
    else if (state_q == STALL)  stall_cnt_d = stall_cnt_q - 4'd1;

    lat_cnt_d = lat_cnt_q;
    if (state_q == ACCESS)      lat_cnt_d = 3'(RD_LAT);
    else if (state_q == RWAIT)  lat_cnt_d = lat_cnt_q - 3'd1;

    // SRAM strobes are registered one cycle early so they are flop outputs
    // exactly during ACCESS; addr_d already equals addr_q outside IDLE.
    to_access    = (state_d == ACCESS);
    oob_d        = is_oob(addr_d);
    sram_cen_d   = to_access && !oob_d;
    sram_wen_d   = to_access && !oob_d && dir_wr_d;
    sram_addr_d  = to_access ? addr_d[ADDR_W-1:0] : sram_addr_q;
    sram_wdata_d = (to_access && dir_wr_d) ? data_d : sram_wdata_q;

    // Capture on the last RWAIT cycle, when SRAM data is valid.
    rdata_d = rdata_q;
    if (state_q == RWAIT && lat_cnt_q == 3'd1)
      rdata_d = is_oob(addr_q) ? '0 : sram_rdata;

    // A new error outranks a simultaneous clear.
    err_oob_d = err_oob_q;
    if (to_access && oob_d) err_oob_d = 1'b1;
    else if (err_clr)       err_oob_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_wr_q     <= 1'b0;
      last_wr_q    <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      stall_cnt_q  <= '0;
      lat_cnt_q    <= '0;
      rdata_q      <= '0;
      err_oob_q    <= 1'b0;
      sram_cen_q   <= 1'b0;
      sram_wen_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      dir_wr_q     <= dir_wr_d;
      last_wr_q    <= last_wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      stall_cnt_q  <= stall_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      rdata_q      <= rdata_d;
      err_oob_q    <= err_oob_d;
      sram_cen_q   <= sram_cen_d;
      sram_wen_q   <= sram_wen_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign wready     = (state_q == RESP) &&  dir_wr_q;
  assign rready     = (state_q == RESP) && !dir_wr_q;
  assign rdata      = rdata_q;
  assign err_oob    = err_oob_q;
  assign sram_cen   = sram_cen_q;
  assign sram_wen   = sram_wen_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_genie_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops
// and checks data, direction, response cycle and the SRAM access it observed.
module tb_genie_mem_responder;
  import genie_mem_responder_pkg::*;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              wvalid, wready, rvalid, rready, err_clr, err_oob;
  logic [MEM_AW-1:0] waddr, raddr;
  logic [MEM_DW-1:0] wdata, rdata, sram_wdata, sram_rdata;
  logic [3:0]        wait_cyc;
  logic              sram_cen, sram_wen;
  logic [ADDR_W-1:0] sram_addr;

  always #5 clk = ~clk;

  genie_mem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
    .wait_cyc(wait_cyc), .err_clr(err_clr), .err_oob(err_oob),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // ---- SRAM model: data valid RD_LAT cycles after the read cycle ----
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rpipe [RD_LAT];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      mem[16'h10] <= 32'hDEADBEEF;
      mem[16'h11] <= 32'hCAFEF00D;
      for (int i = 0; i < 8; i++) mem[16'h40 + i] <= 32'h1000_0000 + i * 32'h111;
      mem_init <= 1'b1;
    end else if (sram_cen && sram_wen) mem[sram_addr] <= sram_wdata;
    rpipe[0] <= (sram_cen && !sram_wen) ? mem[sram_addr] : 32'hBAD0BAD0;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign sram_rdata = rpipe[RD_LAT-1];

  // ---- scoreboard ----
  typedef struct {
    bit          is_rd;
    bit          oob;
    bit          chained;   // accepted in the IDLE cycle right after previous response
    int          wc;
    logic [25:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, issue_cyc = 0, last_resp = 0;
  int cen_cnt = 0, cen_cyc = 0;
  bit cen_wen;
  logic [15:0] cen_addr;
  logic [31:0] cen_wdata;
  logic [25:0] ra [8];
  logic [25:0] wa [4];
  logic [31:0] wd [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_rd, input bit oob, input bit chained, input int wc,
                      input logic [25:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_rd = is_rd; e.oob = oob; e.chained = chained; e.wc = wc; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  exp_t m_e;
  int   m_acc, m_exp;
  always @(negedge clk) begin
    if (!rst_n) cen_cnt = 0;
    else begin
      if (sram_cen) begin
        cen_cnt++; cen_cyc = cyc; cen_wen = sram_wen; cen_addr = sram_addr; cen_wdata = sram_wdata;
      end
      if (rready || wready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: rready=%0b wready=%0b with nothing expected", rready, wready);
        end else begin
          m_e   = sb.pop_front();
          m_acc = m_e.chained ? last_resp + 1 : issue_cyc;
          m_exp = m_acc + 2 + m_e.wc + (m_e.is_rd ? RD_LAT : 0);
          chk("resp_dir", {30'd0, rready, wready}, m_e.is_rd ? 32'd2 : 32'd1);
          chk("resp_cycle", cyc, m_exp);
          if (m_e.is_rd) chk("rdata", rdata, m_e.data);
          if (m_e.oob) begin
            chk("oob_cen_count", cen_cnt, 0);
            chk("err_oob_set", {31'd0, err_oob}, 1);
          end else begin
            chk("cen_count", cen_cnt, 1);
            chk("cen_cycle", cen_cyc, m_exp - 1 - (m_e.is_rd ? RD_LAT : 0));
            chk("cen_addr", {16'd0, cen_addr}, {16'd0, m_e.addr[15:0]});
            chk("cen_wen", {31'd0, cen_wen}, {31'd0, !m_e.is_rd});
            if (!m_e.is_rd) chk("sram_wdata", cen_wdata, m_e.data);
          end
        end
        cen_cnt = 0;
        last_resp = cyc;
      end
    end
  end

  // ---- driver: each channel holds its request until its own ready pulse ----
  task automatic drive(input int rn, input int wn, input int nr, input int nw);
    rvalid = (rn < nr);
    raddr  = ra[(rn < 8) ? rn : 0];
    wvalid = (wn < nw);
    waddr  = wa[(wn < 4) ? wn : 0];
    wdata  = wd[(wn < 4) ? wn : 0];
  endtask

  task automatic run_seq(input int nr, input int nw, input int wc);
    int rn = 0, wn = 0, c = 0;
    @(posedge clk); #1;
    issue_cyc = cyc;
    wait_cyc  = 4'(wc);
    drive(rn, wn, nr, nw);
    while ((rn < nr || wn < nw) && c < 200) begin
      @(negedge clk); c++;
      if (rready) rn++;
      if (wready) wn++;
      @(posedge clk); #1;
      drive(rn, wn, nr, nw);
    end
    if (c >= 200) begin
      checks++; errors++;
      $display("FAIL run_seq_timeout: reads %0d/%0d writes %0d/%0d", rn, nr, wn, nw);
    end
  endtask

  initial begin
    rvalid = 0; wvalid = 0; raddr = '0; waddr = '0; wdata = '0; wait_cyc = '0; err_clr = 0;
    for (int i = 0; i < 8; i++) ra[i] = '0;
    for (int i = 0; i < 4; i++) begin wa[i] = '0; wd[i] = '0; end

    repeat (3) @(posedge clk); #1;
    chk("reset_ready", {30'd0, rready, wready}, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_sram", {15'd0, sram_cen, sram_wen, sram_addr}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Both channels held from reset: read, write, read, write.
    ra[0] = 26'h10; ra[1] = 26'h11;
    wa[0] = 26'h30; wd[0] = 32'hA5A5_0001;
    wa[1] = 26'h31; wd[1] = 32'h5A5A_0002;
    push(1, 0, 0, 0, 26'h10, 32'hDEADBEEF);
    push(0, 0, 1, 0, 26'h30, 32'hA5A5_0001);
    push(1, 0, 1, 0, 26'h11, 32'hCAFEF00D);
    push(0, 0, 1, 0, 26'h31, 32'h5A5A_0002);
    run_seq(2, 2, 0);

    // Write with 3 wait states, then read-backs.
    wa[0] = 26'h20; wd[0] = 32'h1234_5678;
    push(0, 0, 0, 3, 26'h20, 32'h1234_5678);
    run_seq(0, 1, 3);
    ra[0] = 26'h20;
    push(1, 0, 0, 0, 26'h20, 32'h1234_5678);
    run_seq(1, 0, 0);
    ra[0] = 26'h30;
    push(1, 0, 0, 2, 26'h30, 32'hA5A5_0001);
    run_seq(1, 0, 2);

    // Out-of-range read, sticky flag, clear.
    ra[0] = 26'h3FF_FFFF;
    push(1, 1, 0, 0, 26'h3FF_FFFF, 32'h0);
    run_seq(1, 0, 0);
    @(negedge clk) chk("err_oob_sticky", {31'd0, err_oob}, 1);
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    chk("err_oob_cleared", {31'd0, err_oob}, 0);

    // Out-of-range write aliasing 0x20 must be dropped.
    wa[0] = 26'h040_0020; wd[0] = 32'hFFFF_FFFF;
    push(0, 1, 0, 0, 26'h040_0020, 32'hFFFF_FFFF);
    run_seq(0, 1, 0);
    ra[0] = 26'h20;
    push(1, 0, 0, 0, 26'h20, 32'h1234_5678);
    run_seq(1, 0, 0);

    // Back-to-back sequential reads.
    for (int i = 0; i < 8; i++) begin
      ra[i] = 26'h40 + 26'(i);
      push(1, 0, i > 0, 0, 26'h40 + 26'(i), 32'h1000_0000 + i * 32'h111);
    end
    run_seq(8, 0, 0);

    // Reset while a read sits in RWAIT: everything clears, no response.
    @(posedge clk); #1 rvalid = 1; raddr = 26'h10; wait_cyc = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 0; rvalid = 0;
    #1;
    chk("abort_ready", {30'd0, rready, wready}, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_err_oob", {31'd0, err_oob}, 0);
    chk("abort_sram", {15'd0, sram_cen, sram_wen, sram_addr}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    ra[0] = 26'h10;
    push(1, 0, 0, 0, 26'h10, 32'hDEADBEEF);
    run_seq(1, 0, 0);

    repeat (6) @(posedge clk);
    #1 chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/genie_mem_responder.md
GENIE_MEM_RESPONDER -- requirements
Module: genie_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: backing SRAM word-address width; depth = 2^ADDR_W words.
REQ-002 SHALL have parameter RD_LAT, default 1: SRAM read latency in cycles, legal range 1..4.
REQ-003 SHALL have the following ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wvalid  in  1  write request from accelerator.
- wready  out  1  write-accepted pulse.
- waddr  in  26  write word address.
- wdata  in  32  write data.
- rvalid  in  1  read request from accelerator.
- rready  out  1  read-data-valid pulse.
- raddr  in  26  read word address.
- rdata  out  32  read data, valid only while rready=1.
- wait_cyc  in  4  injected wait states per access; sampled at request accept.
- err_clr  in  1  clears err_oob.
- err_oob  out  1  sticky out-of-range flag.
- sram_cen  out  1  SRAM access enable.
- sram_wen  out  1  SRAM write enable; qualifies sram_cen.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid RD_LAT cycles after a read cycle.

Function
REQ-004 SHALL implement states IDLE, STALL, ACCESS, RWAIT, RESP; only one request is in flight at a time.
REQ-005 Requester SHALL hold valid, address and data stable until the matching ready pulse; responder SHALL sample requests only in IDLE.
REQ-006 In IDLE, with exactly one of rvalid/wvalid high, SHALL accept it: latch address, data, direction and wait_cyc.
REQ-007 With both high in IDLE, SHALL grant the direction not granted last (round-robin); first grant after reset SHALL be read.
REQ-008 After accept, SHALL go to STALL when latched wait_cyc>0 and stay there exactly wait_cyc cycles, else go directly to ACCESS.
REQ-009 ACCESS SHALL last one cycle, with sram_cen=1, sram_addr=addr[ADDR_W-1:0], sram_wen=1 and sram_wdata=latched data for a write, sram_wen=0 for a read.
REQ-010 For a write, ACCESS SHALL go to RESP; in RESP, wready=1 for exactly one cycle.
REQ-011 For a read, ACCESS SHALL go to RWAIT for RD_LAT cycles, then capture sram_rdata into rdata and go to RESP; in RESP, rready=1 for exactly one cycle.
REQ-012 Latency, request accepted in cycle T: wready high in cycle T+2+wait_cyc; rready high in cycle T+2+wait_cyc+RD_LAT.
REQ-013 RESP SHALL always go to IDLE; a request seen in that IDLE cycle is a new request.
REQ-014 Out-of-range (addr[25:ADDR_W] != 0): same state sequence and timing; sram_cen SHALL stay 0 in ACCESS; reads return rdata=0; writes are dropped; err_oob is set in the ACCESS cycle.
REQ-015 err_oob SHALL stay set until err_clr=1; a set in the same cycle as err_clr SHALL win.
REQ-016 rdata SHALL hold its last value outside RESP; sram_cen, sram_wen, wready and rready SHALL be 0 in every state not named above.
REQ-017 wready, rready, rdata, err_oob and all SRAM outputs SHALL be driven from registers or decoded directly from the state register; no combinational path from any request input.

Reset
REQ-018 rst_n=0 SHALL immediately force: state=IDLE, wready=0, rready=0, rdata=0, err_oob=0, sram_cen=0, sram_wen=0, sram_addr=0, sram_wdata=0, counters=0, round-robin pointer=write-last.
REQ-019 Reset during any state SHALL abort the in-flight request with no ready pulse; after reset, the requester SHALL re-issue it.

Structure
REQ-020 Shared package SHALL hold: state encoding; MEM_AW=26; MEM_DW=32.
REQ-021 SHALL be a single module with no sub-modules; arbiter, stall counter and latency counter are inline.

Verification
REQ-022 Read, RD_LAT=1, wait_cyc=0, SRAM[0x10]=0xDEADBEEF, rvalid at T -> sram_cen at T+1, rready=1 with rdata=0xDEADBEEF at T+3 only.
REQ-023 Write 0x12345678 to 0x20 with wait_cyc=3 -> sram_cen=sram_wen=1 at T+4, wready at T+5; read-back of 0x20 returns 0x12345678.
REQ-024 rvalid and wvalid held together after reset -> grant order read, write, read, write; no request is lost.
REQ-025 Read of raddr=0x3FFFFFF with ADDR_W=16 -> sram_cen never asserted, rready with rdata=0, err_oob=1; err_clr=1 -> err_oob=0.
REQ-026 rst_n dropped while in RWAIT (RD_LAT=4) -> outputs reach REQ-018 values immediately, no rready; next read completes normally.
REQ-027 Back-to-back reads of 8 sequential addresses with RD_LAT=2 -> each response arrives in order, 4 cycles after its accept cycle.
